sseg_scan_arbiter: RTL and testbench

- Shares the 4-digit, active-low seven-segment display between two pattern sources, A and B.
- Typical sources: the heartbeat animation and a hex/status readout. Each source presents four 8-bit digit patterns.
- Frame-synchronous arbiter picks the owner; a scan controller time-multiplexes the owner's snapshot onto the shared anode/segment pins, with per-slot blanking to suppress ghosting.
- Sits between the pattern generators and the board display pins.

---
 rtl/sseg_scan_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sseg_scan_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sseg_scan_arbiter
// Brief   : Shares a 4-digit active-low seven-segment display between two
//           pattern sources. A frame-synchronous arbiter picks the owner and
//           a scan controller multiplexes the owner's frame snapshot onto the
//           anode/segment pins, with a blank window at the start of each slot.
// Rev     : 1.0  initial release
// ============================================================================
module sseg_scan_arbiter #(
  parameter int SCAN_DIV        = 50000,  // clk cycles per digit slot (>= 2)
  parameter int BLANK_CYCLES    = 500,    // dark cycles at slot start (< SCAN_DIV)
  parameter int MIN_HOLD_FRAMES = 16      // frames kept while contested (>= 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [31:0] a_digits,
  input  logic        b_req,
  input  logic [31:0] b_digits,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        grant_a,
  output logic        grant_b,
  output logic        frame_tick
);

  // Counter widths sized to the largest value each counter must hold.
  localparam int C_SLOT_W = $clog2(SCAN_DIV);
  localparam int C_HOLD_W = (MIN_HOLD_FRAMES > 1) ? $clog2(MIN_HOLD_FRAMES) : 1;

  localparam logic [C_SLOT_W-1:0] C_SLOT_LAST = C_SLOT_W'(SCAN_DIV - 1);
  localparam logic [C_SLOT_W-1:0] C_BLANK     = C_SLOT_W'(BLANK_CYCLES);
  localparam logic [C_HOLD_W-1:0] C_HOLD_MAX  = C_HOLD_W'(MIN_HOLD_FRAMES - 1);
  localparam logic [31:0]         C_DARK      = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [C_SLOT_W-1:0]   r_slot_cnt;
  logic [1:0]            r_idx;
  logic [C_HOLD_W-1:0]   r_hold_cnt;
  logic [31:0]           r_snapshot;
  logic [31:0]           w_next_snapshot;
  logic                  w_slot_wrap;
  logic                  w_fb;
  logic                  w_hold_done;
  logic                  w_blank;
  logic [3:0]            w_an_digit;
  logic [7:0]            w_seg_digit;

  // Frame boundary: last cycle of the last digit slot.
  assign w_slot_wrap = (r_slot_cnt == C_SLOT_LAST);
  assign w_fb        = w_slot_wrap && (r_idx == 2'd3);
  assign w_hold_done = (r_hold_cnt >= C_HOLD_MAX);
  assign w_blank     = (r_slot_cnt < C_BLANK);

  // Slot phase counter and digit index; idx wraps 3->0 at the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_cnt <= '0;
      r_idx      <= 2'd0;
    end else if (w_slot_wrap) begin
      r_slot_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  // Arbiter state register; ownership, hold count and snapshot only move at FB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_snapshot <= C_DARK;
      grant_a    <= 1'b0;
      grant_b    <= 1'b0;
    end else if (w_fb) begin
      r_state    <= w_next_state;
      r_snapshot <= w_next_snapshot;
      grant_a    <= (w_next_state == OWN_A);
      grant_b    <= (w_next_state == OWN_B);
      if (w_next_state != r_state) begin
        r_hold_cnt <= '0;
      end else if (r_hold_cnt != C_HOLD_MAX) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  // Next owner: A wins ties from IDLE; a contested owner yields only once held
  // long enough, but an owner that drops its request yields immediately.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (a_req) begin
          w_next_state = OWN_A;
        end else if (b_req) begin
          w_next_state = OWN_B;
        end
      end
      OWN_A: begin
        if (!a_req) begin
          w_next_state = b_req ? OWN_B : IDLE;
        end else if (b_req && w_hold_done) begin
          w_next_state = OWN_B;
        end
      end
      OWN_B: begin
        if (!b_req) begin
          w_next_state = a_req ? OWN_A : IDLE;
        end else if (a_req && w_hold_done) begin
          w_next_state = OWN_A;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Patterns captured for the coming frame; IDLE captures an all-dark frame.
  always_comb begin
    w_next_snapshot = C_DARK;
    case (w_next_state)
      OWN_A:   w_next_snapshot = a_digits;
      OWN_B:   w_next_snapshot = b_digits;
      default: w_next_snapshot = C_DARK;
    endcase
  end

  // Decode the active digit's anode and pick its byte from the snapshot.
  always_comb begin
    w_an_digit  = 4'hF;
    w_seg_digit = 8'hFF;
    case (r_idx)
      2'd0: begin
        w_an_digit  = 4'b1110;
        w_seg_digit = r_snapshot[7:0];
      end
      2'd1: begin
        w_an_digit  = 4'b1101;
        w_seg_digit = r_snapshot[15:8];
      end
      2'd2: begin
        w_an_digit  = 4'b1011;
        w_seg_digit = r_snapshot[23:16];
      end
      default: begin
        w_an_digit  = 4'b0111;
        w_seg_digit = r_snapshot[31:24];
      end
    endcase
  end

  // Registered pin drivers: dark during the blank window to hide ghosting.
  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= 4'hF;
      seg        <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= w_fb;
      if (w_blank) begin
        an  <= 4'hF;
        seg <= 8'hFF;
      end else begin
        an  <= w_an_digit;
        seg <= w_seg_digit;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sseg_scan_arbiter
// Brief   : Self-checking bench for sseg_scan_arbiter. A frame-level model
//           predicts pins from elapsed cycles, owner and frame snapshot.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sseg_scan_arbiter;

  localparam int SCAN_DIV        = 8;
  localparam int BLANK_CYCLES    = 2;
  localparam int MIN_HOLD_FRAMES = 2;
  localparam int FRAME           = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0;
  logic        b_req = 1'b0;
  logic [31:0] a_digits = 32'h0;
  logic [31:0] b_digits = 32'h0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        grant_a;
  logic        grant_b;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  sseg_scan_arbiter #(
    .SCAN_DIV(SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .MIN_HOLD_FRAMES(MIN_HOLD_FRAMES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_req(a_req),
    .a_digits(a_digits),
    .b_req(b_req),
    .b_digits(b_digits),
    .an(an),
    .seg(seg),
    .grant_a(grant_a),
    .grant_b(grant_b),
    .frame_tick(frame_tick)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model: position in the frame comes from cycles elapsed since
  // reset; owner and snapshot change only when a frame completes.
  int          m_edges;
  int          m_owner;   // 0 none, 1 A, 2 B
  int          m_shown;   // frames the current owner has been on screen
  logic [31:0] m_snap;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_ga, exp_gb, exp_ft;

  initial begin
    int pos, slot, phase, prev;
    logic [3:0] one;
    m_edges = 0; m_owner = 0; m_shown = 0; m_snap = 32'hFFFF_FFFF;
    exp_an = 4'hF; exp_seg = 8'hFF; exp_ga = 1'b0; exp_gb = 1'b0; exp_ft = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_edges = 0; m_owner = 0; m_shown = 0; m_snap = 32'hFFFF_FFFF;
        exp_an = 4'hF; exp_seg = 8'hFF; exp_ga = 1'b0; exp_gb = 1'b0; exp_ft = 1'b0;
      end else begin
        pos   = m_edges % FRAME;
        slot  = pos / SCAN_DIV;
        phase = pos % SCAN_DIV;
        if (phase < BLANK_CYCLES) begin
          exp_an  = 4'hF;
          exp_seg = 8'hFF;
        end else begin
          one     = 4'b0001 << slot;
          exp_an  = ~one;
          exp_seg = m_snap[8*slot +: 8];
        end
        exp_ft = (pos == FRAME - 1);
        if (pos == FRAME - 1) begin
          prev = m_owner;
          case (m_owner)
            0: m_owner = a_req ? 1 : (b_req ? 2 : 0);
            1: if (!a_req) m_owner = b_req ? 2 : 0;
               else if (b_req && m_shown >= MIN_HOLD_FRAMES) m_owner = 2;
            default: if (!b_req) m_owner = a_req ? 1 : 0;
               else if (a_req && m_shown >= MIN_HOLD_FRAMES) m_owner = 1;
          endcase
          m_shown = (m_owner != prev) ? 1 : m_shown + 1;
          m_snap  = (m_owner == 1) ? a_digits :
                    (m_owner == 2) ? b_digits : 32'hFFFF_FFFF;
          exp_ga  = (m_owner == 1);
          exp_gb  = (m_owner == 2);
        end
        m_edges++;
      end
    end
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Hold reset for two edges and release it on a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    a_req = 1'b0; b_req = 1'b0;
    a_digits = $urandom; b_digits = $urandom;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, seg, grant_a, grant_b, frame_tick} !== {4'hF, 8'hFF, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got an=%h seg=%h ga=%b gb=%b ft=%b want F FF 0 0 0",
               an, seg, grant_a, grant_b, frame_tick);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("FAIL idle_disp c=%0d an/seg=%h/%h want %h/%h", c, an, seg, exp_an, exp_seg);
      end
      checks++;
      if ({grant_a, grant_b, frame_tick} !== {exp_ga, exp_gb, exp_ft}) begin
        errors++;
        $display("FAIL idle_ctl c=%0d ga/gb/ft=%b%b%b want %b%b%b", c, grant_a, grant_b,
                 frame_tick, exp_ga, exp_gb, exp_ft);
      end
      checks++;
      if (frame_tick !== ((c % FRAME) == 0)) begin
        errors++;
        $display("FAIL idle_tick c=%0d frame_tick=%b want %b", c, frame_tick, (c % FRAME) == 0);
      end
    end
  endtask

  task automatic test_single_a();
    a_req = 1'b1; b_req = 1'b0;
    a_digits = 32'hC0F9_A4B0; b_digits = $urandom;
    apply_reset();
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("FAIL single_disp c=%0d an/seg=%h/%h want %h/%h", c, an, seg, exp_an, exp_seg);
      end
      checks++;
      if ({grant_a, grant_b, frame_tick} !== {exp_ga, exp_gb, exp_ft}) begin
        errors++;
        $display("FAIL single_ctl c=%0d ga/gb/ft=%b%b%b want %b%b%b", c, grant_a, grant_b,
                 frame_tick, exp_ga, exp_gb, exp_ft);
      end
      if (c == 32 || c == 33 || c == 35 || c == 43 || c == 51 || c == 59) begin
        logic [12:0] want;
        case (c)
          32:      want = {4'b0111, 8'hFF, 1'b1};
          33:      want = {4'hF,    8'hFF, 1'b1};
          35:      want = {4'b1110, 8'hB0, 1'b1};
          43:      want = {4'b1101, 8'hA4, 1'b1};
          51:      want = {4'b1011, 8'hF9, 1'b1};
          default: want = {4'b0111, 8'hC0, 1'b1};
        endcase
        checks++;
        if ({an, seg, grant_a} !== want) begin
          errors++;
          $display("FAIL single_fixed c=%0d an/seg/ga=%h/%h/%b want %h/%h/%b", c, an, seg,
                   grant_a, want[12:9], want[8:1], want[0]);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] gexp [5];
    logic [1:0] prev_g;
    gexp = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
    a_req = 1'b1; b_req = 1'b1;
    a_digits = $urandom; b_digits = $urandom;
    apply_reset();
    prev_g = 2'b00;
    for (int c = 1; c <= 170; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("FAIL contend_disp c=%0d an/seg=%h/%h want %h/%h", c, an, seg, exp_an, exp_seg);
      end
      checks++;
      if ({grant_a, grant_b, frame_tick} !== {exp_ga, exp_gb, exp_ft}) begin
        errors++;
        $display("FAIL contend_ctl c=%0d ga/gb/ft=%b%b%b want %b%b%b", c, grant_a, grant_b,
                 frame_tick, exp_ga, exp_gb, exp_ft);
      end
      if ((c % FRAME) == 0) begin
        checks++;
        if ({grant_a, grant_b} !== gexp[c / FRAME - 1]) begin
          errors++;
          $display("FAIL contend_seq frame=%0d grants=%b want %b", c / FRAME, {grant_a, grant_b},
                   gexp[c / FRAME - 1]);
        end
      end
      checks++;
      if (({grant_a, grant_b} != prev_g) && !frame_tick) begin
        errors++;
        $display("FAIL contend_sync c=%0d grants %b->%b frame_tick=%b want 1", c, prev_g,
                 {grant_a, grant_b}, frame_tick);
      end
      prev_g = {grant_a, grant_b};
    end
  endtask

  task automatic test_no_tearing();
    logic [31:0] old_digits;
    old_digits = 32'hF9A4_B0C0;
    a_req = 1'b1; b_req = 1'b0;
    a_digits = old_digits;
    apply_reset();
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("FAIL tear_disp c=%0d an/seg=%h/%h want %h/%h", c, an, seg, exp_an, exp_seg);
      end
      checks++;
      if ({grant_a, grant_b, frame_tick} !== {exp_ga, exp_gb, exp_ft}) begin
        errors++;
        $display("FAIL tear_ctl c=%0d ga/gb/ft=%b%b%b want %b%b%b", c, grant_a, grant_b,
                 frame_tick, exp_ga, exp_gb, exp_ft);
      end
      if (c == 52) begin
        checks++;
        if (seg !== old_digits[23:16]) begin
          errors++;
          $display("FAIL tear_old c=%0d seg=%h want %h", c, seg, old_digits[23:16]);
        end
      end
      if (c == 84) begin
        checks++;
        if (seg !== 8'h88) begin
          errors++;
          $display("FAIL tear_new c=%0d seg=%h want 88", c, seg);
        end
      end
      if (c == 40) a_digits = 32'h8888_8888;
    end
  endtask

  task automatic test_drop(input logic b_waiting);
    a_req = 1'b1; b_req = 1'b0;
    a_digits = $urandom; b_digits = $urandom;
    apply_reset();
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("FAIL drop_disp c=%0d an/seg=%h/%h want %h/%h", c, an, seg, exp_an, exp_seg);
      end
      checks++;
      if ({grant_a, grant_b, frame_tick} !== {exp_ga, exp_gb, exp_ft}) begin
        errors++;
        $display("FAIL drop_ctl c=%0d ga/gb/ft=%b%b%b want %b%b%b", c, grant_a, grant_b,
                 frame_tick, exp_ga, exp_gb, exp_ft);
      end
      if (c == 64) begin
        checks++;
        if ({grant_a, grant_b} !== {1'b0, b_waiting}) begin
          errors++;
          $display("FAIL drop_owner c=%0d grants=%b want %b", c, {grant_a, grant_b},
                   {1'b0, b_waiting});
        end
      end
      if (c == 84 && !b_waiting) begin
        checks++;
        if ({an, seg} !== {4'b1011, 8'hFF}) begin
          errors++;
          $display("FAIL drop_dark c=%0d an/seg=%h/%h want b/ff", c, an, seg);
        end
      end
      if (c == 36) b_req = b_waiting;
      if (c == 45) a_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    a_req = 1'b0; b_req = 1'b1;
    b_digits = $urandom;
    apply_reset();
    repeat (45) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, seg, grant_a, grant_b, frame_tick} !== {4'hF, 8'hFF, 3'b000}) begin
      errors++;
      $display("FAIL midreset_state got an=%h seg=%h ga=%b gb=%b ft=%b want F FF 0 0 0",
               an, seg, grant_a, grant_b, frame_tick);
    end
    reset = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("FAIL midreset_disp c=%0d an/seg=%h/%h want %h/%h", c, an, seg, exp_an, exp_seg);
      end
      checks++;
      if ({grant_a, grant_b, frame_tick} !== {exp_ga, exp_gb, exp_ft}) begin
        errors++;
        $display("FAIL midreset_ctl c=%0d ga/gb/ft=%b%b%b want %b%b%b", c, grant_a, grant_b,
                 frame_tick, exp_ga, exp_gb, exp_ft);
      end
      if (c == 31 || c == 32) begin
        checks++;
        if (grant_b !== (c == 32)) begin
          errors++;
          $display("FAIL midreset_grant c=%0d grant_b=%b want %b", c, grant_b, c == 32);
        end
      end
    end
  endtask

  task automatic test_random();
    a_req = 1'b0; b_req = 1'b0;
    apply_reset();
    for (int c = 1; c <= 40 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("FAIL rand_disp c=%0d an/seg=%h/%h want %h/%h", c, an, seg, exp_an, exp_seg);
      end
      checks++;
      if ({grant_a, grant_b, frame_tick} !== {exp_ga, exp_gb, exp_ft}) begin
        errors++;
        $display("FAIL rand_ctl c=%0d ga/gb/ft=%b%b%b want %b%b%b", c, grant_a, grant_b,
                 frame_tick, exp_ga, exp_gb, exp_ft);
      end
      checks++;
      if (grant_a && grant_b) begin
        errors++;
        $display("FAIL rand_excl c=%0d grants=11 want at most one", c);
      end
      if ($urandom_range(0, 19) == 0) a_req = ~a_req;
      if ($urandom_range(0, 19) == 0) b_req = ~b_req;
      if ($urandom_range(0, 15) == 0) a_digits = $urandom;
      if ($urandom_range(0, 15) == 0) b_digits = $urandom;
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_contention();
    test_no_tearing();
    test_drop(1'b1);
    test_drop(1'b0);
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
